// File: rtl/dm_pkg.sv
// Shared definitions for the data memory and its access arbiter:
// access-type encodings, arbiter state enum and access size helper.
package dm_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } dm_arb_state_t;

    // Zero marks an encoding that is not a legal access type.
    function automatic logic [2:0] dm_nbytes(input logic [2:0] t);
        case (t)
            DM_WORD:            return 3'd4;
            DM_HALF, DM_HALF_U: return 3'd2;
            DM_BYTE, DM_BYTE_U: return 3'd1;
            default:            return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of both requester handshakes plus the shared dm access port.
interface dm_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          m0_req, m0_wr, m0_ack, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [2:0]    m0_type;

    logic          m1_req, m1_wr, m1_ack, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [2:0]    m1_type;

    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din, dm_dout;
    logic [2:0]    dm_type;
    logic          busy;

    modport arb (
        input  m0_req, m0_wr, m0_addr, m0_wdata, m0_type,
        input  m1_req, m1_wr, m1_addr, m1_wdata, m1_type,
        input  dm_dout,
        output m0_ack, m0_rdata, m0_err,
        output m1_ack, m1_rdata, m1_err,
        output dm_we, dm_addr, dm_din, dm_type, busy
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata, m0_type,
        output m1_req, m1_wr, m1_addr, m1_wdata, m1_type,
        input  m0_ack, m0_rdata, m0_err,
        input  m1_ack, m1_rdata, m1_err, busy
    );

    modport mem (
        input  dm_we, dm_addr, dm_din, dm_type,
        output dm_dout
    );

endinterface

// File: rtl/dm_rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the port that did
// not win last time is chosen.
module dm_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_gnt_valid,
    output logic       o_gnt_id
);

    assign o_gnt_valid = |i_req;

    always_comb begin
        o_gnt_id = i_req[1];
        if (i_req == 2'b11)
            o_gnt_id = ~i_last_grant;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the byte-addressed data memory: one
// access per grant, IDLE -> ACCESS -> DONE, all outputs registered.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic      clk,
    input  logic      rst,
    dm_arbiter_if.arb bus
);

    localparam logic [AW:0] MEM_BYTES = {1'b1, {AW{1'b0}}};

    dm_arb_state_t r_state;
    logic          r_last_grant, r_gid, r_wr, r_err, r_busy;
    logic          r_m0_ack, r_m1_ack, r_m0_err, r_m1_err;
    logic [DW-1:0] r_m0_rdata, r_m1_rdata;
    logic          r_dm_we;
    logic [AW-1:0] r_dm_addr;
    logic [DW-1:0] r_dm_din;
    logic [2:0]    r_dm_type;

    logic          w_gnt_valid, w_gnt_id, w_tie, w_sel_wr, w_err;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata, w_rdata_cap;
    logic [2:0]    w_sel_type, w_nb;
    logic [AW:0]   w_end;

    dm_rr_arb2 u_rr (
        .i_req        ({bus.m1_req, bus.m0_req}),
        .i_last_grant (r_last_grant),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_id     (w_gnt_id)
    );

    assign w_tie       = bus.m0_req & bus.m1_req;
    assign w_sel_wr    = w_gnt_id ? bus.m1_wr    : bus.m0_wr;
    assign w_sel_addr  = w_gnt_id ? bus.m1_addr  : bus.m0_addr;
    assign w_sel_wdata = w_gnt_id ? bus.m1_wdata : bus.m0_wdata;
    assign w_sel_type  = w_gnt_id ? bus.m1_type  : bus.m0_type;

    // One extra bit so an access ending exactly at the top of memory is legal.
    assign w_nb        = dm_nbytes(w_sel_type);
    assign w_end       = {1'b0, w_sel_addr} + (AW+1)'(w_nb);
    assign w_err       = (w_nb == 3'd0) || (w_end > MEM_BYTES);
    assign w_rdata_cap = (r_wr | r_err) ? '0 : bus.dm_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_gid        <= 1'b0;
            r_wr         <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_dm_we      <= 1'b0;
            r_dm_addr    <= '0;
            r_dm_din     <= '0;
            r_dm_type    <= DM_WORD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        if (w_tie)
                            r_last_grant <= w_gnt_id;
                        r_gid     <= w_gnt_id;
                        r_wr      <= w_sel_wr;
                        r_err     <= w_err;
                        r_dm_we   <= w_sel_wr & ~w_err;
                        r_dm_addr <= w_sel_addr;
                        r_dm_din  <= w_sel_wdata;
                        r_dm_type <= w_sel_type;
                        r_busy    <= 1'b1;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_dm_we   <= 1'b0;
                    r_dm_addr <= '0;
                    r_dm_din  <= '0;
                    r_dm_type <= DM_WORD;
                    r_m0_ack  <= ~r_gid;
                    r_m1_ack  <= r_gid;
                    // Only the granted port's rdata moves; the other keeps its last value.
                    if (r_gid) begin
                        r_m1_rdata <= w_rdata_cap;
                        r_m1_err   <= r_err;
                    end else begin
                        r_m0_rdata <= w_rdata_cap;
                        r_m0_err   <= r_err;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_m0_err <= 1'b0;
                    r_m1_err <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.m0_ack   = r_m0_ack;
    assign bus.m0_err   = r_m0_err;
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m1_ack   = r_m1_ack;
    assign bus.m1_err   = r_m1_err;
    assign bus.m1_rdata = r_m1_rdata;
    assign bus.dm_we    = r_dm_we;
    assign bus.dm_addr  = r_dm_addr;
    assign bus.dm_din   = r_dm_din;
    assign bus.dm_type  = r_dm_type;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: byte memory behind the dm port, a transaction-level
// reference model checked every cycle, and directed literal checks.
module tb_dm_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(7), .DW(32)) bus ();

    dm_arbiter #(.AW(7), .DW(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes_of(input logic [2:0] t);
        case (t)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] r, input logic [2:0] t);
        case (t)
            3'd0:    return r;
            3'd1:    return {{16{r[15]}}, r[15:0]};
            3'd2:    return {16'h0, r[15:0]};
            3'd3:    return {{24{r[7]}}, r[7:0]};
            3'd4:    return {24'h0, r[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- memory attached to the dm port ----------------
    logic [7:0]  env_mem [128] = '{default: 8'h00};
    logic [31:0] env_raw;

    always_comb begin
        env_raw = '0;
        for (int i = 0; i < 4; i++)
            if (int'(bus.dm_addr) + i < 128)
                env_raw[8*i +: 8] = env_mem[int'(bus.dm_addr) + i];
        bus.dm_dout = fmt(env_raw, bus.dm_type);
    end

    always @(posedge clk)
        if (bus.dm_we)
            for (int i = 0; i < 4; i++)
                if (i < nbytes_of(bus.dm_type) && int'(bus.dm_addr) + i < 128)
                    env_mem[int'(bus.dm_addr) + i] <= bus.dm_din[8*i +: 8];

    // ---------------- reference model ----------------
    typedef struct {
        int          gid;
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  typ;
        logic        err;
        logic [31:0] rd;
    } mtx_t;

    logic [7:0] smem [128] = '{default: 8'h00};
    int   ph     = 0;   // 0: no transaction, 1: on the dm port, 2: ack cycle
    int   m_last = 1;
    mtx_t tx;

    function automatic mtx_t model_grant(
        input logic r0, input logic r1, input int last,
        input logic wr0, input logic [6:0] a0, input logic [31:0] d0, input logic [2:0] t0,
        input logic wr1, input logic [6:0] a1, input logic [31:0] d1, input logic [2:0] t1);
        mtx_t        x;
        logic [31:0] raw;
        int          nb;
        if (r0 && r1) x.gid = (last == 1) ? 0 : 1;
        else          x.gid = r1 ? 1 : 0;
        x.wr    = x.gid ? wr1 : wr0;
        x.addr  = x.gid ? a1  : a0;
        x.wdata = x.gid ? d1  : d0;
        x.typ   = x.gid ? t1  : t0;
        nb      = nbytes_of(x.typ);
        x.err   = (nb == 0) || (int'(x.addr) + nb > 128);
        raw     = '0;
        for (int i = 0; i < 4; i++)
            if (int'(x.addr) + i < 128) raw[8*i +: 8] = smem[int'(x.addr) + i];
        x.rd = (x.wr || x.err) ? 32'h0 : fmt(raw, x.typ);
        return x;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph     <= 0;
            m_last <= 1;
        end else if (ph == 1) begin
            ph <= 2;
            if (tx.wr && !tx.err)
                for (int i = 0; i < 4; i++)
                    if (i < nbytes_of(tx.typ))
                        smem[int'(tx.addr) + i] <= tx.wdata[8*i +: 8];
        end else if (ph == 2) begin
            ph <= 0;
        end else if (bus.m0_req || bus.m1_req) begin
            tx <= model_grant(bus.m0_req, bus.m1_req, m_last,
                              bus.m0_wr, bus.m0_addr, bus.m0_wdata, bus.m0_type,
                              bus.m1_wr, bus.m1_addr, bus.m1_wdata, bus.m1_type);
            if (bus.m0_req && bus.m1_req) m_last <= (m_last == 1) ? 0 : 1;
            ph <= 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (bus.dm_we === 1'b1) we_cnt++;
        if (rst || ph == 0) begin
            chk("idle_busy",  32'(bus.busy),    0);
            chk("idle_ack0",  32'(bus.m0_ack),  0);
            chk("idle_ack1",  32'(bus.m1_ack),  0);
            chk("idle_err0",  32'(bus.m0_err),  0);
            chk("idle_err1",  32'(bus.m1_err),  0);
            chk("idle_we",    32'(bus.dm_we),   0);
            chk("idle_addr",  32'(bus.dm_addr), 0);
            chk("idle_din",   bus.dm_din,       0);
            chk("idle_type",  32'(bus.dm_type), 0);
            if (rst) begin
                chk("rst_rdata0", bus.m0_rdata, 0);
                chk("rst_rdata1", bus.m1_rdata, 0);
            end
        end else if (ph == 1) begin
            chk("acc_busy", 32'(bus.busy),    1);
            chk("acc_ack0", 32'(bus.m0_ack),  0);
            chk("acc_ack1", 32'(bus.m1_ack),  0);
            chk("acc_we",   32'(bus.dm_we),   32'(tx.wr & ~tx.err));
            chk("acc_addr", 32'(bus.dm_addr), 32'(tx.addr));
            chk("acc_din",  bus.dm_din,       tx.wdata);
            chk("acc_type", 32'(bus.dm_type), 32'(tx.typ));
        end else begin
            chk("done_busy", 32'(bus.busy),   1);
            chk("done_ack0", 32'(bus.m0_ack), 32'(tx.gid == 0));
            chk("done_ack1", 32'(bus.m1_ack), 32'(tx.gid == 1));
            chk("done_we",   32'(bus.dm_we),  0);
            chk("done_addr", 32'(bus.dm_addr), 0);
            if (tx.gid == 0) begin
                chk("done_rdata0", bus.m0_rdata,     tx.rd);
                chk("done_err0",   32'(bus.m0_err),  32'(tx.err));
                chk("done_err1",   32'(bus.m1_err),  0);
            end else begin
                chk("done_rdata1", bus.m1_rdata,     tx.rd);
                chk("done_err1",   32'(bus.m1_err),  32'(tx.err));
                chk("done_err0",   32'(bus.m0_err),  0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_port(input int p, input logic rq, input logic wr,
                            input logic [6:0] a, input logic [31:0] d, input logic [2:0] t);
        if (p == 0) begin
            bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_type = t; bus.m0_req = rq;
        end else begin
            bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_type = t; bus.m1_req = rq;
        end
    endtask

    task automatic do_req(input int p, input logic wr, input logic [6:0] a,
                          input logic [31:0] d, input logic [2:0] t,
                          output logic [31:0] rd, output logic e, output int lat);
        bit got;
        got = 0; rd = '0; e = 1'b0; lat = 0;
        @(posedge clk); #1;
        set_port(p, 1'b1, wr, a, d, t);
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if ((p == 0 && bus.m0_ack) || (p == 1 && bus.m1_ack)) begin
                got = 1;
                rd  = p ? bus.m1_rdata : bus.m0_rdata;
                e   = p ? bus.m1_err   : bus.m0_err;
            end
        end
        chk("ack_seen", 32'(got), 1);
        @(posedge clk); #1;
        if (p == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, expected $finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          we0;
        int          ord[$];

        set_port(0, 1'b0, 1'b0, 7'h0, 32'h0, 3'd0);
        set_port(1, 1'b0, 1'b0, 7'h0, 32'h0, 3'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        chk("reset_rdata0", bus.m0_rdata,    0);
        chk("reset_rdata1", bus.m1_rdata,    0);
        chk("reset_busy",   32'(bus.busy),   0);
        chk("reset_we",     32'(bus.dm_we),  0);

        // word write on port 0, read back on port 1
        do_req(0, 1'b1, 7'h10, 32'hDEADBEEF, 3'd0, rd, e, lat);
        chk("wr_latency", 32'(lat), 2);
        chk("wr_err",     32'(e),   0);
        do_req(1, 1'b0, 7'h10, 32'h0, 3'd0, rd, e, lat);
        chk("rd_word", rd, 32'hDEADBEEF);

        // sub-word reads of a byte with the sign bit set
        do_req(0, 1'b1, 7'h20, 32'h00000080, 3'd3, rd, e, lat);
        do_req(0, 1'b0, 7'h20, 32'h0, 3'd3, rd, e, lat);
        chk("rd_byte_s", rd, 32'hFFFFFF80);
        do_req(1, 1'b0, 7'h20, 32'h0, 3'd4, rd, e, lat);
        chk("rd_byte_u", rd, 32'h00000080);
        do_req(0, 1'b0, 7'h20, 32'h0, 3'd1, rd, e, lat);
        chk("rd_half_s", rd, 32'h00000080);
        do_req(1, 1'b0, 7'h11, 32'h0, 3'd1, rd, e, lat);
        chk("rd_half_mis", rd, 32'hFFFFADBE);

        // both ports requesting continuously from reset
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 7'h10, 32'h0, 3'd0);
        set_port(1, 1'b0, 1'b0, 7'h20, 32'h0, 3'd3);
        @(posedge clk); #1;
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        for (int i = 0; i < 40 && ord.size() < 4; i++) begin
            @(negedge clk);
            if (bus.m0_ack) ord.push_back(0);
            if (bus.m1_ack) ord.push_back(1);
        end
        @(posedge clk); #1;
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        chk("tie_count", 32'(ord.size()), 4);
        for (int i = 0; i < 4; i++)
            chk("tie_order", (i < ord.size()) ? 32'(ord[i]) : 32'hFFFFFFFF, 32'(i % 2));

        // accesses at the top of memory
        do_req(0, 1'b1, 7'h7E, 32'h0000005A, 3'd3, rd, e, lat);
        we0 = we_cnt;
        do_req(1, 1'b1, 7'h7E, 32'hAABBCCDD, 3'd0, rd, e, lat);
        chk("oor_err", 32'(e), 1);
        chk("oor_no_we", 32'(we_cnt - we0), 0);
        do_req(0, 1'b0, 7'h7E, 32'h0, 3'd3, rd, e, lat);
        chk("oor_old", rd, 32'h0000005A);
        do_req(1, 1'b1, 7'h7C, 32'h11223344, 3'd0, rd, e, lat);
        chk("top_word_err", 32'(e), 0);
        do_req(0, 1'b0, 7'h7E, 32'h0, 3'd3, rd, e, lat);
        chk("top_byte", rd, 32'h00000022);
        do_req(0, 1'b0, 7'h7F, 32'h0, 3'd1, rd, e, lat);
        chk("half_7f_err", 32'(e), 1);
        chk("half_7f_rd",  rd, 32'h0);
        do_req(1, 1'b0, 7'h7F, 32'h0, 3'd4, rd, e, lat);
        chk("byte_7f_err", 32'(e), 0);
        chk("byte_7f_rd",  rd, 32'h00000011);

        // illegal access types
        do_req(1, 1'b1, 7'h00, 32'hCAFEF00D, 3'd0, rd, e, lat);
        we0 = we_cnt;
        do_req(0, 1'b1, 7'h00, 32'h12345678, 3'd5, rd, e, lat);
        chk("ill_err",   32'(e), 1);
        chk("ill_rd",    rd, 32'h0);
        chk("ill_no_we", 32'(we_cnt - we0), 0);
        do_req(1, 1'b0, 7'h00, 32'h0, 3'd0, rd, e, lat);
        chk("ill_unchanged", rd, 32'hCAFEF00D);
        do_req(1, 1'b0, 7'h00, 32'h0, 3'd7, rd, e, lat);
        chk("ill7_err", 32'(e), 1);

        // reset while a read is on the dm port
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 7'h10, 32'h0, 3'd0);
        @(posedge clk); #2;
        chk("midop_busy", 32'(bus.busy),    1);
        chk("midop_addr", 32'(bus.dm_addr), 32'h10);
        rst = 1'b1;
        #1;
        chk("async_busy", 32'(bus.busy),    0);
        chk("async_addr", 32'(bus.dm_addr), 0);
        chk("async_we",   32'(bus.dm_we),   0);
        bus.m0_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        chk("post_rst_ack", 32'(bus.m0_ack), 0);
        do_req(0, 1'b0, 7'h10, 32'h0, 3'd0, rd, e, lat);
        chk("reissue_rd",  rd, 32'hDEADBEEF);
        chk("reissue_lat", 32'(lat), 2);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the byte-addressed data memory `dm`. It shares the single `dm` access port between the core load/store unit (port 0) and a debug/DMA port (port 1), using round-robin priority. Each port has a req/ack handshake. The arbiter latches one request at a time, drives the memory's write-enable, address, data and type lines for one access cycle, captures the read data, and returns it with an ack pulse. Requests that would run past the end of memory, and unknown access types, are rejected with an error and leave memory unchanged.

## Interface
- `AW`, 7: byte-address width. Memory depth is 2^AW bytes.
- `DW`, 32: data width.
- `clk` in 1: clock. Everything updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req` in 1: port 0 request. Held with its fields stable until `m0_ack`.
- `m0_wr` in 1: port 0 access is a write (1) or a read (0).
- `m0_addr` in AW: port 0 byte address.
- `m0_wdata` in DW: port 0 write data.
- `m0_type` in 3: port 0 access type (word/half/half-u/byte/byte-u = 000/001/010/011/100).
- `m0_ack` out 1: port 0 one-cycle completion pulse.
- `m0_rdata` out DW: port 0 read data. Valid while `m0_ack` is high.
- `m0_err` out 1: port 0 error. Valid while `m0_ack` is high.
- `m1_req`, `m1_wr`, `m1_addr`, `m1_wdata`, `m1_type`, `m1_ack`, `m1_rdata`, `m1_err`: same as port 0, for port 1.
- `dm_we` out 1: write enable to `dm`.
- `dm_addr` out AW: address to `dm`.
- `dm_din` out DW: write data to `dm`.
- `dm_type` out 3: access type to `dm`.
- `dm_dout` in DW: combinational read data from `dm`.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE:**
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both reqs: grant the port that is not `last_grant`, then set `last_grant` to the winner.
  - On grant: latch the winner's wr/addr/wdata/type into internal registers, compute `err`, go to ACCESS.
- **Error check:** `err = 1` when either holds:
  - type is 101, 110 or 111;
  - addr + nbytes > 2^AW, where nbytes is 4, 2 or 1 by type. Compute in AW+1 bits.
  - Misaligned in-range accesses are legal.
- **ACCESS:**
  - `dm_addr`, `dm_din` and `dm_type` come from the latched registers.
  - `dm_we = wr & ~err`.
  - At the end of the cycle, capture `dm_dout` into `rdata_q`. For writes or errors, capture 0 instead. Go to DONE.
- **DONE:**
  - Pulse ack for the granted port. Drive its rdata from `rdata_q` and its err.
  - The other port's ack stays 0.
  - Return to IDLE.
- **Requester rule:** drop req in the ack cycle unless a new transaction is presented. Any req seen in the IDLE cycle after DONE is a new request.
- Every output is registered.
- Outside ACCESS, `dm_we`, `dm_addr`, `dm_din` and `dm_type` are 0, which is type word.
- `mX_rdata` holds its last value. It is meaningful only while `mX_ack` is high.

## Timing
- Reset values:
  - FSM goes to IDLE. `last_grant = 1`, so port 0 wins the first tie.
  - All acks and errs are 0. `rdata_q` and both rdata outputs are 0. `dm_*` outputs are 0. `busy` is 0.
- Latency and throughput:
  - A req high at rising edge E0 (FSM in IDLE) puts the access on the `dm` port during cycle E0..E1.
  - ack is high during cycle E1..E2.
  - At most one transaction completes per 3 cycles. Under continuous contention the two ports alternate.
- A write commits to `dm` on edge E1.
- Read data is sampled from `dm` on the same edge E1, so the read returns the memory contents from before any write committed at E1.
- A port whose req rises while the other port is in service waits until the next IDLE.
- A req that drops before it is granted is ignored.
- Reset asserted in any state:
  - Returns to IDLE immediately and `dm_we` clears asynchronously.
  - A pending transaction is lost and no ack is issued.
  - Requesters must reissue after reset deasserts.

## Structure
- Shared package `dm_pkg` holds:
  - the DMType encodings (`DM_WORD`…`DM_BYTE_U`), shared with `dm`;
  - the state enum `dm_arb_state_t`;
  - a function `dm_nbytes(type)`.
- One sub-module, `dm_rr_arb2`: a combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: `gnt_valid`, `gnt_id`.
  - The FSM owns the `last_grant` register.

## Test plan
- **Port 0 word write, then port 1 word read.**
  - Port 0 writes addr 0x10, data 0xDEADBEEF, type 000. Then port 1 reads addr 0x10, type 000.
  - Required: `m0_ack` two cycles after req, err 0. `m1_rdata` = 0xDEADBEEF.
- **Signed and unsigned sub-word reads.**
  - Port 0 writes byte 0x80 at addr 0x20.
  - Byte read (011) returns 0xFFFFFF80. Byte-unsigned read (100) returns 0x00000080.
  - Halfword read (001) at 0x20, with 0x21 = 0x00, returns 0x00000080.
- **Simultaneous requests.**
  - Both reqs held high for 4 transactions from reset.
  - Grant order is 0, 1, 0, 1. Exactly one ack per DONE cycle. `busy` is low for one cycle between transactions.
- **Out-of-range write.**
  - Word write at addr 0x7E.
  - Required: `m1_err` = 1, `dm_we` never asserts. A read of 0x7E with type 011 returns the old value.
  - Word at 0x7C: err 0.
- **Illegal type.**
  - Type 101 write at addr 0x00, data 0x12345678.
  - Required: err = 1, rdata = 0, memory unchanged.
- **Reset mid-operation.**
  - Assert `rst` while in ACCESS for a read.
  - Required: no ack issued, all outputs at their reset values, FSM in IDLE.
  - After release, the reissued request completes normally.
